// File: rtl/clock_divider_ctrl_pkg.sv
// Shared types and constants for the programmable clock divider controller.
package clock_divider_ctrl_pkg;

  typedef enum logic {
    PARKED = 1'b0,
    RUN    = 1'b1
  } state_t;

  localparam int MIN_DIV = 2;

endpackage

// File: rtl/clock_divider_ctrl.sv
// Programmable divider producing a registered clock-level (clk_d) for a downstream clock flop.
// Divisor changes are queued and applied only at period boundaries or while parked.
module clock_divider_ctrl
  import clock_divider_ctrl_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int RESET_DIV = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] req_divisor,
  output logic             clk_d,
  output logic             period_start,
  output logic [WIDTH-1:0] cur_divisor,
  output logic             running
);

  localparam logic [WIDTH-1:0] RESET_VAL = WIDTH'(RESET_DIV);
  localparam logic [WIDTH-1:0] MIN_VAL   = WIDTH'(MIN_DIV);

  // Handshake: a request transfers on any cycle with req_valid && req_ready.
  // req_ready is low while a divisor is held pending, and rises the cycle after it loads.
  state_t           state;
  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] pend_div;
  logic             pend;

  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] cnt_inc;
  logic [WIDTH-1:0] req_coerced;
  logic             last;
  logic             accept;

  assign req_ready   = !pend;
  assign accept      = req_valid && req_ready;
  assign hi          = {1'b0, cur_divisor[WIDTH-1:1]};
  assign cnt_inc     = cnt + 1'b1;
  assign last        = (cnt == cur_divisor - 1'b1);
  assign req_coerced = (req_divisor < MIN_VAL) ? MIN_VAL : req_divisor;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= PARKED;
      running      <= 1'b0;
      cnt          <= '0;
      clk_d        <= 1'b0;
      period_start <= 1'b0;
      cur_divisor  <= RESET_VAL;
      pend         <= 1'b0;
      pend_div     <= RESET_VAL;
    end else begin
      period_start <= 1'b0;

      // Accept and load are exclusive: accept needs !pend, load needs pend.
      if (accept) begin
        pend     <= 1'b1;
        pend_div <= req_coerced;
      end

      case (state)
        RUN: begin
          if (!last) begin
            cnt   <= cnt_inc;
            clk_d <= (cnt_inc < hi);
          end else if (enable) begin
            cnt          <= '0;
            clk_d        <= 1'b1;
            period_start <= 1'b1;
            if (pend) begin
              cur_divisor <= pend_div;
              pend        <= 1'b0;
            end
          end else begin
            state   <= PARKED;
            running <= 1'b0;
            cnt     <= '0;
            clk_d   <= 1'b0;
          end
        end
        default: begin
          if (pend) begin
            cur_divisor <= pend_div;
            pend        <= 1'b0;
          end
          if (enable) begin
            state        <= RUN;
            running      <= 1'b1;
            cnt          <= '0;
            clk_d        <= 1'b1;
            period_start <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_divider_ctrl.sv
// Directed bench for clock_divider_ctrl: waveform-queue model checked every cycle,
// period-length monitor, and hand-computed literal checkpoints.
module tb_clock_divider_ctrl;

  localparam int WIDTH     = 8;
  localparam int RESET_DIV = 2;

  // clock/reset block
  logic             clock = 1'b0;
  logic             reset;
  logic             enable;
  logic             req_valid;
  logic             req_ready;
  logic [WIDTH-1:0] req_divisor;
  logic             clk_d;
  logic             period_start;
  logic [WIDTH-1:0] cur_divisor;
  logic             running;

  always #5 clock = ~clock;

  clock_divider_ctrl #(.WIDTH(WIDTH), .RESET_DIV(RESET_DIV)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_divisor  (req_divisor),
    .clk_d        (clk_d),
    .period_start (period_start),
    .cur_divisor  (cur_divisor),
    .running      (running)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: each period is a queue of expected clk_d levels, refilled at every start.
  logic [0:0] exp_q[$];
  int  m_n       = RESET_DIV;
  int  m_pend_val = 0;
  bit  m_pend    = 1'b0;
  bit  m_clk     = 1'b0;
  bit  m_ps      = 1'b0;
  bit  m_running = 1'b0;
  bit  m_valid   = 1'b0;
  bit  m_acc;
  bit  m_start;

  always @(posedge clock) begin
    m_acc   = req_valid && !m_pend;
    m_start = 1'b0;
    if (reset) begin
      exp_q.delete();
      m_n       = RESET_DIV;
      m_pend    = 1'b0;
      m_clk     = 1'b0;
      m_ps      = 1'b0;
      m_running = 1'b0;
      m_valid   = 1'b1;
    end else begin
      m_ps = 1'b0;
      if (m_running) begin
        if (exp_q.size() == 0) begin
          if (enable) m_start = 1'b1;
          else begin
            m_running = 1'b0;
            m_clk     = 1'b0;
          end
        end else begin
          m_clk = exp_q.pop_front();
        end
      end else if (enable) begin
        m_start = 1'b1;
      end else if (m_pend) begin
        m_n    = m_pend_val;
        m_pend = 1'b0;
      end
      if (m_start) begin
        if (m_pend) begin
          m_n    = m_pend_val;
          m_pend = 1'b0;
        end
        for (int i = 0; i < m_n; i++) exp_q.push_back((i < m_n / 2) ? 1'b1 : 1'b0);
        m_clk     = exp_q.pop_front();
        m_ps      = 1'b1;
        m_running = 1'b1;
      end
      if (m_acc) begin
        m_pend     = 1'b1;
        m_pend_val = (req_divisor < 2) ? 2 : int'(req_divisor);
      end
    end
  end

  // Scoreboard compare plus period/high-phase length monitor.
  int mon_len = 0;
  int mon_n   = 0;
  int hi_len  = 0;
  bit mon_active = 1'b0;
  bit prev_clk   = 1'b0;

  always @(negedge clock) begin
    if (m_valid) begin
      lit("clk_d", clk_d, m_clk);
      lit("period_start", period_start, m_ps);
      lit("running", running, m_running);
      lit("cur_divisor", cur_divisor, m_n);
      lit("req_ready", req_ready, !m_pend);
    end
    if (reset) begin
      mon_active = 1'b0;
    end else if (period_start) begin
      if (mon_active) lit("period_len", mon_len, mon_n);
      mon_active = 1'b1;
      mon_n      = m_n;
      mon_len    = 1;
      hi_len     = 1;
    end else if (running && mon_active) begin
      mon_len++;
      if (clk_d) hi_len++;
    end else if (mon_active) begin
      lit("period_len_park", mon_len, mon_n);
      mon_active = 1'b0;
    end
    if (mon_active && !clk_d && prev_clk) lit("high_len", hi_len, mon_n / 2);
    prev_clk = clk_d;
  end

  // driver tasks
  task automatic tick();
    @(negedge clock);
  endtask

  task automatic set_in(input bit en, input bit rv, input logic [WIDTH-1:0] d, input bit rst);
    #1;
    enable      = en;
    req_valid   = rv;
    req_divisor = d;
    reset       = rst;
  endtask

  task automatic wait_ps(input int budget);
    int k = 0;
    do begin
      tick();
      k++;
    end while (period_start !== 1'b1 && k < budget);
    if (period_start !== 1'b1) lit("wait_ps_timeout", 0, 1);
  endtask

  task automatic request(input logic [WIDTH-1:0] d, input bit en);
    set_in(en, 1'b1, d, 1'b0);
    tick();
    set_in(en, 1'b0, '0, 1'b0);
  endtask

  logic exp5[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
  logic exp_park_clk[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
  logic exp_park_run[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [WIDTH-1:0] sweep[3] = '{8'd1, 8'd3, 8'd8};
  int guard;

  initial begin
    reset = 1'b1; enable = 1'b0; req_valid = 1'b0; req_divisor = '0;
    repeat (2) tick();
    lit("rst_clk", clk_d, 0);
    lit("rst_cur", cur_divisor, 2);
    lit("rst_ready", req_ready, 1);
    lit("rst_run", running, 0);
    lit("rst_ps", period_start, 0);

    // N=2 from reset: rise one cycle after enable, toggle each cycle
    set_in(1, 0, '0, 0);
    tick(); lit("n2_clk_a", clk_d, 1); lit("n2_ps_a", period_start, 1);
    tick(); lit("n2_clk_b", clk_d, 0); lit("n2_ps_b", period_start, 0);
    tick(); lit("n2_clk_c", clk_d, 1); lit("n2_ps_c", period_start, 1);

    // divisor 5 while running N=2
    request(8'd5, 1);
    lit("req5_ready_low", req_ready, 0);
    tick();
    lit("req5_ps", period_start, 1);
    lit("req5_cur", cur_divisor, 5);
    lit("req5_ready_back", req_ready, 1);
    lit("req5_clk0", clk_d, exp5[0]);
    for (int i = 1; i < 5; i++) begin
      tick();
      lit("req5_wave", clk_d, exp5[i]);
    end
    tick(); lit("req5_next_ps", period_start, 1);

    // divisor 0 coerced to 2
    request(8'd0, 1);
    wait_ps(10);
    lit("req0_cur", cur_divisor, 2);

    // request on the exact period-end cycle: one more N=4 period, then 7
    request(8'd4, 1);
    wait_ps(10);
    lit("req4_cur", cur_divisor, 4);
    repeat (3) tick();
    set_in(1, 1, 8'd7, 0);
    tick();
    set_in(1, 0, '0, 0);
    lit("req7_ps_old", period_start, 1);
    lit("req7_cur_old", cur_divisor, 4);
    lit("req7_ready", req_ready, 0);
    repeat (3) tick();
    tick();
    lit("req7_ps_new", period_start, 1);
    lit("req7_cur_new", cur_divisor, 7);

    // N=6, enable dropped at cnt=1: period completes, then parks
    request(8'd6, 1);
    wait_ps(12);
    lit("req6_cur", cur_divisor, 6);
    tick();
    set_in(0, 0, '0, 0);
    for (int i = 0; i < 5; i++) begin
      tick();
      lit("park_clk", clk_d, exp_park_clk[i]);
      lit("park_run", running, exp_park_run[i]);
    end
    tick(); lit("parked_clk", clk_d, 0);
    set_in(1, 0, '0, 0);
    tick();
    lit("reen_clk", clk_d, 1);
    lit("reen_ps", period_start, 1);

    // divisor loaded while parked with enable low
    set_in(0, 0, '0, 0);
    guard = 0;
    do begin tick(); guard++; end while (running !== 1'b0 && guard < 12);
    lit("park2_run", running, 0);
    request(8'd3, 0);
    lit("pk_ready_low", req_ready, 0);
    tick();
    lit("pk_cur", cur_divisor, 3);
    lit("pk_ready_back", req_ready, 1);
    set_in(1, 0, '0, 0);
    tick(); lit("n3_clk_a", clk_d, 1);
    tick(); lit("n3_clk_b", clk_d, 0);

    // reset mid-period with an update pending
    request(8'd9, 1);
    set_in(1, 0, '0, 1);
    tick();
    lit("mrst_clk", clk_d, 0);
    lit("mrst_cur", cur_divisor, RESET_DIV);
    lit("mrst_ready", req_ready, 1);
    lit("mrst_run", running, 0);
    set_in(1, 0, '0, 0);

    // short sweep of further divisors under the model
    foreach (sweep[i]) begin
      request(sweep[i], 1);
      wait_ps(20);
      wait_ps(20);
    end
    repeat (20) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_divider_ctrl.md
CLOCK_DIVIDER_CTRL -- requirements
Module: clock_divider_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, divisor width in bits.
REQ-002 SHALL have parameter RESET_DIV, default 2, divisor loaded at reset (legal range 2..2^WIDTH-1).
REQ-003 SHALL have port clock  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port enable  input  1  run request; low parks the divided clock low at the end of the current period.
REQ-006 SHALL have port req_valid  input  1  new-divisor request valid.
REQ-007 SHALL have port req_ready  output  1  high when no divisor update is pending.
REQ-008 SHALL have port req_divisor  input  WIDTH  requested divisor, in input-clock cycles per output period.
REQ-009 SHALL have port clk_d  output  1  registered divided-clock level; drives the D input of the downstream clock flop.
REQ-010 SHALL have port period_start  output  1  high for one cycle on each cycle where clk_d rises.
REQ-011 SHALL have port cur_divisor  output  WIDTH  divisor currently in effect.
REQ-012 SHALL have port running  output  1  high in RUN state.

Function
REQ-013 SHALL implement states PARKED and RUN; counter cnt in 0..N-1, where N = cur_divisor and hi = floor(N/2).
REQ-014 In RUN, clk_d SHALL equal 1 exactly when cnt < hi, i.e. high for floor(N/2) cycles and low for N-floor(N/2) cycles per period.
REQ-015 In RUN with cnt < N-1, cnt SHALL increment by one per cycle.
REQ-016 In RUN with cnt == N-1 (period end) and enable high: cnt <= 0, clk_d <= 1, period_start <= 1, and any pending divisor is loaded into cur_divisor.
REQ-017 In RUN with cnt == N-1 and enable low: next state PARKED, clk_d <= 0, cnt <= 0.
REQ-018 Dropping enable mid-period SHALL NOT truncate the period; clk_d completes its full high and low phases first.
REQ-019 In PARKED with enable high: next state RUN, cnt <= 0, clk_d <= 1, period_start <= 1, pending divisor loaded first.
REQ-020 In PARKED with enable low, a pending divisor SHALL be loaded on the following cycle.
REQ-021 A request SHALL be accepted on a cycle with req_valid && req_ready; req_ready SHALL be low from the next cycle until the cycle after the pending value is loaded.
REQ-022 Accepted req_divisor values 0 and 1 SHALL be coerced to 2.
REQ-023 A request accepted on a period-end cycle SHALL NOT take effect at that boundary; it is applied at the next boundary.
REQ-024 cur_divisor SHALL change only at a period boundary or in PARKED, so no output phase is shorter than floor(N_old/2) or floor(N_new/2) cycles.
REQ-025 clk_d, period_start and running SHALL be driven directly from flops, with no combinational path from inputs.

Reset
REQ-026 On reset: state PARKED, cnt 0, clk_d 0, period_start 0, running 0, cur_divisor RESET_DIV, no pending request, req_ready 1.
REQ-027 Reset asserted mid-period SHALL take effect on the next edge and discard any pending divisor.

Structure
REQ-028 A shared package SHALL hold the state enum (PARKED, RUN) and the minimum-divisor constant (2).
REQ-029 The block SHALL be a single module with no sub-modules; the clock flop and any clock gating are instantiated by the parent.

Verification
REQ-030 Reset, enable=1, RESET_DIV=2 -> clk_d rises 1 cycle after enable and toggles every cycle; period_start every 2 cycles.
REQ-031 Request 5 while running N=2 -> req_ready drops; at the next boundary clk_d runs 2 high/3 low; req_ready returns 1 the cycle after the load.
REQ-032 Request 0 -> cur_divisor becomes 2, never 0 or 1.
REQ-033 N=6 running, enable dropped at cnt=1 -> clk_d stays high through cnt=2, low through cnt=5, then PARKED with clk_d 0; re-enable -> clk_d 1 the next cycle.
REQ-034 Request accepted on the exact cycle cnt==N-1 (N=4, new 7) -> one more 4-cycle period, then 7-cycle periods.
REQ-035 Reset asserted mid-period with an update pending -> clk_d 0, cur_divisor RESET_DIV, req_ready 1 on the next cycle; PeriodMonitor on the divided clock reports no short period across all scenarios.
